// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 13;

  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Modulo-PRESCALE counter; tick is high for the one enabled cycle that wraps it.
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  // Combinational so the count moves on the same edge the prescaler wraps.
  assign tick = enable && (phase == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (enable) begin
      if (phase == LAST) phase <= '0;
      else               phase <= phase + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with load and done handshakes.
// Optional auto-reload on expiry: define COUNTDOWN_TIMER_RELOAD_EN.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output state_t           state
);

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; valid is held by the producer until then and never depends on ready.

  logic tick;
  logic pre_clear;
  logic pre_enable;

  assign pre_clear  = abort || (state != RUN);
  assign pre_enable = (state == RUN) && !pause;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

`ifdef COUNTDOWN_TIMER_RELOAD_EN
  logic [WIDTH-1:0] reload_value;
`endif

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      load_ready <= 1'b1;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
      if (reset) reload_value <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            count      <= load_value;
            load_ready <= 1'b0;
`ifdef COUNTDOWN_TIMER_RELOAD_EN
            reload_value <= load_value;
`endif
            if (load_value != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state      <= DONE;
              done_valid <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef COUNTDOWN_TIMER_RELOAD_EN
          // Clear first so a same-edge expiry overrides the acknowledge.
          if (done_ready) done_valid <= 1'b0;
          if (tick && count != '0) begin
            if (count == WIDTH'(1)) begin
              count      <= reload_value;
              done_valid <= 1'b1;
            end else begin
              count <= count - WIDTH'(1);
            end
          end
`else
          if (tick && count != '0) begin
            count <= count - WIDTH'(1);
            if (count == WIDTH'(1)) begin
              state      <= DONE;
              busy       <= 1'b0;
              done_valid <= 1'b1;
            end
          end
`endif
        end
        DONE: begin
          if (done_ready) begin
            state      <= IDLE;
            done_valid <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          count      <= '0;
          busy       <= 1'b0;
          done_valid <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that pairs with the free-running up-counter.
- Accepts a start value through a valid/ready load handshake and decrements it once per prescaled tick.
- Raises a held done event with a valid/ready handshake when the count reaches zero.
- Sits beside the up-counter in timing/sequencing logic, where software or a sequencer arms interval delays.

Parameters:
- WIDTH, 13, bit width of count and load_value.
- PRESCALE, 1, clock cycles per decrement; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load request.
- load_value  in  WIDTH  start value.
- load_ready  out  1  high when a load can be accepted (state IDLE).
- pause  in  1  level; freezes count and prescaler while high.
- abort  in  1  cancels any activity and returns to IDLE.
- count  out  WIDTH  current remaining value.
- busy  out  1  high in RUN.
- done_valid  out  1  expiry event pending.
- done_ready  in  1  consumer acknowledge of done_valid.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state IDLE, count 0, prescaler 0, busy 0, done_valid 0, load_ready 1.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only. No combinational input-to-output paths.
- Priority per edge: reset > abort > load/run/done logic.
- abort, any state: next state IDLE, count 0, prescaler 0, done_valid 0.
- IDLE:
  - load_ready=1.
  - On load_valid: count<=load_value, prescaler<=0.
  - Next state RUN if load_value!=0. If load_value==0, next state DONE (done_valid=1 next cycle).
- RUN:
  - busy=1, load_ready=0. load_valid is ignored.
  - When pause=0: the prescaler increments. On reaching PRESCALE-1 it wraps to 0 and generates a tick.
  - On tick: count<=count-1.
  - Tick while count==1: count<=0, state DONE, done_valid<=1.
  - When pause=1: prescaler and count hold exactly.
- Latency: load N accepted at edge E0 with pause held low means done_valid first reads 1 after edge E0+N*PRESCALE. count equals N-k after edge E0+k*PRESCALE.
- DONE:
  - busy=0, load_ready=0, done_valid=1, count=0. pause has no effect.
  - done_ready=1 at an edge: done_valid<=0, state IDLE.
  - A load is possible the cycle after the done handshake.
- Arithmetic: count never underflows. Decrement occurs only in RUN with count>=1. No wrap-around of count.
- Prescaler width is max(1, clog2(PRESCALE)). With PRESCALE=1, every unpaused RUN cycle is a tick.
- Reset or abort mid-count discards the count and any pending done event. No done event is generated.

Optional Feature:
- Macro: COUNTDOWN_TIMER_RELOAD_EN.
- Defined:
  - Accepted load_value is also stored in a reload register.
  - Expiry in RUN sets count<=reload value, keeps state RUN with prescaler 0, and sets done_valid<=1.
  - done_valid clears on done_ready. If an expiry and done_ready occur on the same edge, the set wins.
  - RUN is left only via abort or reset. A load of 0 still goes to DONE as in base behaviour, with no reload.
- Undefined: base behaviour exactly, no reload register.

Decomposition:
- Package countdown_timer_pkg holds the state enum typedef (IDLE, RUN, DONE) and the default WIDTH constant (13).
- One natural sub-module, tick_prescaler, with ports clock, reset, clear, enable, tick. It is a modulo-PRESCALE counter whose tick pulses for one cycle on wrap.

Test Plan:
- Reset then load 5, PRESCALE=1, pause low:
  - load_ready 1 before load, 0 after.
  - count reads 5,4,3,2,1,0 on successive edges.
  - done_valid=1 exactly 5 cycles after accept.
  - Holding done_ready low keeps done_valid high. One cycle of done_ready returns to IDLE with load_ready=1.
- PRESCALE=4, load 3: count decrements every 4th cycle. done_valid after 12 cycles.
- Load 6 with pause high for 7 cycles mid-run: count and prescaler frozen, done delayed by exactly 7 cycles (done at 13 for PRESCALE=1).
- Load 0: next cycle DONE with done_valid=1 and busy never asserted.
- Abort at count=3, and separately synchronous reset at count=3: next edge count=0, state IDLE, done_valid=0. No done event ever appears.
- With COUNTDOWN_TIMER_RELOAD_EN, load 2, done_ready low:
  - count sequence 2,1,2,1,…; done_valid stays 1 and busy stays 1.
  - done_ready asserted on an expiry edge leaves done_valid=1.
